// File: rtl/relay_bank_seq_if.sv
// Bus-side view of the relay sequencer: one-cycle data-phase strobe, address
// decode, direction and the two 32-bit data paths.
interface relay_bank_seq_if;
  logic        valid_pci;
  logic        rd_wr;
  logic        relay_bank_sel;
  logic [31:0] ad_to_tuvv;
  logic [31:0] ad_from_tuvv;

  modport master (
    output valid_pci,
    output rd_wr,
    output relay_bank_sel,
    output ad_to_tuvv,
    input  ad_from_tuvv
  );

  modport slave (
    input  valid_pci,
    input  rd_wr,
    input  relay_bank_sel,
    input  ad_to_tuvv,
    output ad_from_tuvv
  );
endinterface

// File: rtl/relay_bank_seq.sv
// Break-before-make relay coil sequencer with a one-deep pending command,
// sticky overrun flag and zero-latency status readback.
module relay_bank_seq #(
  parameter int N_CH       = 8,
  parameter int BREAK_CYC  = 3300,
  parameter int SETTLE_CYC = 165000,
  parameter int CNT_W      = 18
) (
  input  logic              clk,
  input  logic              rst_,
  relay_bank_seq_if.slave   bus,
  output logic [N_CH-1:0]   relay,
  output logic              relay_busy
);

  // ST_BREAK holds the opened contacts for the remainder of the break time
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPEN   = 3'd1,
    ST_BREAK  = 3'd2,
    ST_CLOSE  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_KILL = 2'b11;

  localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [N_CH-1:0]  CH_ZERO     = {N_CH{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [N_CH-1:0]   relay_r, relay_nxt_s;
  logic [N_CH-1:0]   tgt_r, tgt_nxt_s;
  logic [N_CH-1:0]   pend_r, pend_nxt_s;
  logic              pend_v_r, pend_v_nxt_s;
  logic              overrun_r, overrun_nxt_s;
  logic              busy_r, busy_nxt_s;

  logic              wr_s, rd_s;
  logic [1:0]        op_s;
  logic [N_CH-1:0]   mask_s, base_s, cmd_s;
  logic [23:0]       relay_ext_s;
  logic [31:0]       rdata_s;

  assign wr_s   = bus.valid_pci & bus.relay_bank_sel & bus.rd_wr;
  assign rd_s   = bus.valid_pci & bus.relay_bank_sel & ~bus.rd_wr;
  assign op_s   = bus.ad_to_tuvv[31:30];
  assign mask_s = bus.ad_to_tuvv[N_CH-1:0];

  // New target: the command applied to the most recent intended state
  always_comb begin
    if (pend_v_r) begin
      base_s = pend_r;
    end else if (state_r != ST_IDLE) begin
      base_s = tgt_r;
    end else begin
      base_s = relay_r;
    end
    case (op_s)
      OP_LOAD: cmd_s = mask_s;
      OP_SET:  cmd_s = base_s | mask_s;
      OP_CLR:  cmd_s = base_s & ~mask_s;
      default: cmd_s = base_s;
    endcase
  end

  // Sequencer next state; bus writes are applied last so KILL overrides everything
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    relay_nxt_s   = relay_r;
    tgt_nxt_s     = tgt_r;
    pend_nxt_s    = pend_r;
    pend_v_nxt_s  = pend_v_r;
    overrun_nxt_s = overrun_r;

    case (state_r)
      ST_IDLE: begin
        // A command parked in pending during DONE is picked up here
        if (pend_v_r) begin
          tgt_nxt_s    = pend_r;
          pend_v_nxt_s = 1'b0;
          state_nxt_s  = ST_OPEN;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_OPEN: begin
        relay_nxt_s = relay_r & tgt_r;
        if (((relay_r & ~tgt_r) == CH_ZERO) || (BREAK_LOAD == CNT_W'(0))) begin
          cnt_nxt_s   = CNT_W'(0);
          state_nxt_s = ST_CLOSE;
        end else begin
          cnt_nxt_s   = BREAK_LOAD;
          state_nxt_s = ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_CLOSE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      ST_CLOSE: begin
        relay_nxt_s = tgt_r;
        if (tgt_r == relay_r) begin
          cnt_nxt_s   = CNT_W'(0);
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = SETTLE_LOAD;
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_DONE: begin
        if (pend_v_r) begin
          tgt_nxt_s    = pend_r;
          pend_v_nxt_s = 1'b0;
          state_nxt_s  = ST_OPEN;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      default: begin
        relay_nxt_s  = CH_ZERO;
        cnt_nxt_s    = CNT_W'(0);
        pend_v_nxt_s = 1'b0;
        state_nxt_s  = ST_IDLE;
      end
    endcase

    if (rd_s) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_nxt_s;
    end

    if (wr_s) begin
      if (op_s == OP_KILL) begin
        relay_nxt_s  = CH_ZERO;
        cnt_nxt_s    = CNT_W'(0);
        pend_v_nxt_s = 1'b0;
        state_nxt_s  = ST_IDLE;
      end else if (state_r == ST_IDLE) begin
        tgt_nxt_s    = cmd_s;
        state_nxt_s  = ST_OPEN;
      end else begin
        pend_nxt_s   = cmd_s;
        pend_v_nxt_s = 1'b1;
        if (pend_v_r) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_nxt_s;
        end
      end
    end else begin
      tgt_nxt_s = tgt_nxt_s;
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE) | pend_v_nxt_s;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_W'(0);
      relay_r   <= CH_ZERO;
      tgt_r     <= CH_ZERO;
      pend_r    <= CH_ZERO;
      pend_v_r  <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      relay_r   <= relay_nxt_s;
      tgt_r     <= tgt_nxt_s;
      pend_r    <= pend_nxt_s;
      pend_v_r  <= pend_v_nxt_s;
      overrun_r <= overrun_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // Status readback; the bus is driven to zero unless this block is read
  always_comb begin
    relay_ext_s            = 24'd0;
    relay_ext_s[N_CH-1:0]  = relay_r;
    if (rd_s) begin
      rdata_s = {busy_r, pend_v_r, overrun_r, 5'd0, relay_ext_s};
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.ad_from_tuvv = rdata_s;
  assign relay            = relay_r;
  assign relay_busy       = busy_r;

endmodule

// File: tb/tb_relay_bank_seq.sv
// Directed bench for relay_bank_seq: reads are scoreboarded against
// hand-computed status words, checked by a monitor on the falling edge.
module tb_relay_bank_seq;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] SET  = 2'b01;
  localparam logic [1:0] CLR  = 2'b10;
  localparam logic [1:0] KILL = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic [23:0] relay;
    logic        busy;
  } exp_t;

  logic        clk;
  logic        rst_;
  logic [7:0]  relay0;
  logic        busy0;
  logic [23:0] relay1;
  logic        busy1;
  int          n_cmp;
  int          n_fail;
  exp_t        q0[$];
  exp_t        q1[$];

  relay_bank_seq_if bus0();
  relay_bank_seq_if bus1();

  relay_bank_seq #(.N_CH(8), .BREAK_CYC(4), .SETTLE_CYC(10), .CNT_W(8)) dut0 (
    .clk(clk), .rst_(rst_), .bus(bus0), .relay(relay0), .relay_busy(busy0)
  );

  relay_bank_seq #(.N_CH(24), .BREAK_CYC(2), .SETTLE_CYC(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst_(rst_), .bus(bus1), .relay(relay1), .relay_busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic b, input logic pv, input logic ov,
                              input logic [23:0] r);
    exp_t e;
    e.rdata = {b, pv, ov, 5'd0, r};
    e.relay = r;
    e.busy  = b;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus data phase, entered and left at posedge+1
  task automatic bus_cyc(input int d, input logic sel, input logic wr,
                         input logic [31:0] data);
    if (d == 0) begin
      bus0.valid_pci = 1'b1; bus0.relay_bank_sel = sel;
      bus0.rd_wr = wr;       bus0.ad_to_tuvv = data;
    end else begin
      bus1.valid_pci = 1'b1; bus1.relay_bank_sel = sel;
      bus1.rd_wr = wr;       bus1.ad_to_tuvv = data;
    end
    @(posedge clk); #1;
    bus0.valid_pci = 1'b0; bus0.relay_bank_sel = 1'b0; bus0.rd_wr = 1'b0; bus0.ad_to_tuvv = 32'd0;
    bus1.valid_pci = 1'b0; bus1.relay_bank_sel = 1'b0; bus1.rd_wr = 1'b0; bus1.ad_to_tuvv = 32'd0;
  endtask

  task automatic wr(input int d, input logic [1:0] op, input logic [29:0] m);
    bus_cyc(d, 1'b1, 1'b1, {op, m});
  endtask

  task automatic rd(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    bus_cyc(d, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops an expectation for every read strobe, else bus must be zero
  always @(negedge clk) begin
    exp_t e;
    if (bus0.valid_pci && bus0.relay_bank_sel && !bus0.rd_wr) begin
      if (q0.size() == 0) begin
        chk("unexpected_read0", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("rdata0", bus0.ad_from_tuvv, e.rdata);
        chk("relay0", {24'd0, relay0}, {8'd0, e.relay});
        chk("busy0", {31'd0, busy0}, {31'd0, e.busy});
      end
    end else begin
      chk("idle_bus0", bus0.ad_from_tuvv, 32'd0);
    end
    if (bus1.valid_pci && bus1.relay_bank_sel && !bus1.rd_wr) begin
      if (q1.size() == 0) begin
        chk("unexpected_read1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("rdata1", bus1.ad_from_tuvv, e.rdata);
        chk("relay1", {8'd0, relay1}, {8'd0, e.relay});
        chk("busy1", {31'd0, busy1}, {31'd0, e.busy});
      end
    end else begin
      chk("idle_bus1", bus1.ad_from_tuvv, 32'd0);
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_ = 1'b0;
    bus0.valid_pci = 1'b0; bus0.relay_bank_sel = 1'b0; bus0.rd_wr = 1'b0; bus0.ad_to_tuvv = 32'd0;
    bus1.valid_pci = 1'b0; bus1.relay_bank_sel = 1'b0; bus1.rd_wr = 1'b0; bus1.ad_to_tuvv = 32'd0;
    idle(3);
    rst_ = 1'b1;

    // Reset state
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h0));
    rd(1, mk(1'b0, 1'b0, 1'b0, 24'h0));
    // Unselected read leaves the bus at zero
    bus_cyc(0, 1'b0, 1'b0, 32'd0);

    // Establish relay = 0F
    wr(0, LOAD, 30'h0F);
    idle(16);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h0F));

    // LOAD F0 from 0F: open for 4 cycles, then close and settle 10
    wr(0, LOAD, 30'hF0);
    for (int k = 0; k < 18; k++) begin
      rd(0, mk(k < 16, 1'b0, 1'b0, (k == 0) ? 24'h0F : ((k < 5) ? 24'h00 : 24'hF0)));
    end

    // Establish relay = 01, then SET 02 with nothing to open
    wr(0, LOAD, 30'h01);
    idle(25);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h01));
    wr(0, SET, 30'h02);
    for (int k = 0; k < 15; k++) begin
      rd(0, mk(k < 13, 1'b0, 1'b0, (k < 2) ? 24'h01 : 24'h03));
    end

    // Two writes during SETTLE: pending then overrun; overrun clears after a read
    wr(0, SET, 30'h08);
    idle(3);
    wr(0, SET, 30'h04);
    wr(0, CLR, 30'h01);
    rd(0, mk(1'b1, 1'b1, 1'b1, 24'h0B));
    rd(0, mk(1'b1, 1'b1, 1'b0, 24'h0B));
    idle(25);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h0E));

    // KILL mid-open with a command pending
    wr(0, LOAD, 30'h30);
    wr(0, SET, 30'h01);
    rd(0, mk(1'b1, 1'b1, 1'b0, 24'h00));
    wr(0, KILL, 30'h0);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h00));
    idle(10);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h00));
    // Mask bits beyond N_CH are ignored
    wr(0, LOAD, 30'h0000_FF05);
    rd(0, mk(1'b1, 1'b0, 1'b0, 24'h00));
    idle(20);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h05));

    // Reset while SETTLE is active
    wr(0, LOAD, 30'h0A);
    idle(7);
    rd(0, mk(1'b1, 1'b0, 1'b0, 24'h0A));
    rst_ = 1'b0;
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h00));
    rst_ = 1'b1;
    idle(2);
    rd(0, mk(1'b0, 1'b0, 1'b0, 24'h00));

    // 24-channel instance: all coils
    wr(1, LOAD, 30'h00FF_FFFF);
    rd(1, mk(1'b1, 1'b0, 1'b0, 24'h0));
    idle(8);
    rd(1, mk(1'b0, 1'b0, 1'b0, 24'hFFFFFF));

    idle(2);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
